// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ctrl_pkg
// Purpose  : Shared definitions for the register-file write arbiter.
//            Provides the default widths, the PC register address and the
//            round-robin requester identifier.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

  localparam int N_DEF = 4;
  localparam int M_DEF = 32;

  // R15 is the PC; the register file loads it from a dedicated input.
  localparam logic [3:0] PC_ADDR = 4'hF;

  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ_EX) ? REQ_MEM : REQ_EX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Writeback request channel (valid/ready handshake with a
//            destination register address and write data).
// Ports    : valid  - request present (master -> slave)
//            ready  - slave can accept (slave -> master)
//            addr   - destination register, N bits
//            data   - write data, M bits
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if
  import regfile_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
);

  logic         valid;
  logic         ready;
  logic [N-1:0] addr;
  logic [M-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Small in-order writeback buffer. Exposes its head entry, its
//            occupancy and a flat {valid, addr} vector of every slot so the
//            owner can detect pending writes to a register.
// Ports    : clk, reset (async, active-low)
//            push, push_addr, push_data - enqueue (caller guarantees not full)
//            pop                        - dequeue (caller guarantees not empty)
//            head_addr, head_data       - oldest entry
//            count                      - occupancy, 0..DEPTH
//            entries                    - slot i at [i*(N+1) +: N+1] = {vld, addr}
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import regfile_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [N-1:0]             push_addr,
  input  logic [M-1:0]             push_data,
  input  logic                     pop,
  output logic [N-1:0]             head_addr,
  output logic [M-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH*(N+1)-1:0]   entries
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  r_addr_mem [DEPTH];
  logic [M-1:0]  r_data_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Storage carries no reset; slot validity is derived from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      r_addr_mem[r_wptr] <= push_addr;
      r_data_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_addr = r_addr_mem[r_rptr];
  assign head_data = r_data_mem[r_rptr];
  assign count     = r_count;

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [AW-1:0] w_off;
    assign w_off = AW'(i) - r_rptr;
    assign entries[i*(N+1) +: N+1] = {({1'b0, w_off} < r_count), r_addr_mem[i]};
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single register-file write port between execute
//            (req0) and memory (req1) writeback. Each requester is buffered,
//            a round-robin grant issues one write per cycle, writes to R15
//            are diverted to a PC-write pulse, and pend1/pend2 flag
//            outstanding writes to the decode-stage read addresses.
// Ports    : clk, reset (async, active-low)
//            req0, req1           - writeback request channels (slave side)
//            we3, a3, wd3         - registered register-file write port
//            pc_wr_valid/_data    - registered one-cycle PC write
//            a1, a2               - decode read addresses
//            pend1, pend2         - write to a1/a2 still outstanding
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_write_arbiter_if.slave    req0,
  regfile_write_arbiter_if.slave    req1,
  output logic                      we3,
  output logic [N-1:0]              a3,
  output logic [M-1:0]              wd3,
  output logic                      pc_wr_valid,
  output logic [M-1:0]              pc_wr_data,
  input  logic [N-1:0]              a1,
  input  logic [N-1:0]              a2,
  output logic                      pend1,
  output logic                      pend2
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]          w_cnt0, w_cnt1;
  logic [N-1:0]           w_head0_addr, w_head1_addr;
  logic [M-1:0]           w_head0_data, w_head1_data;
  logic [DEPTH*(N+1)-1:0] w_ent0, w_ent1;
  logic                   w_push0, w_push1;
  logic                   w_gnt0, w_gnt1;
  logic [N-1:0]           w_gnt_addr;
  logic [M-1:0]           w_gnt_data;
  req_id_t                r_ptr, w_ptr_nxt;

  logic                   r_we3;
  logic [N-1:0]           r_a3;
  logic [M-1:0]           r_wd3;
  logic                   r_pc_wr_valid;
  logic [M-1:0]           r_pc_wr_data;

  // Ready comes from registered count only, so it stays low on a full
  // FIFO even in a cycle where that FIFO is being popped.
  assign req0.ready = reset && (w_cnt0 < CW'(DEPTH));
  assign req1.ready = reset && (w_cnt1 < CW'(DEPTH));
  assign w_push0    = req0.valid && req0.ready;
  assign w_push1    = req1.valid && req1.ready;

  wb_fifo #(.N(N), .M(M), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push0),
    .push_addr (req0.addr),
    .push_data (req0.data),
    .pop       (w_gnt0),
    .head_addr (w_head0_addr),
    .head_data (w_head0_data),
    .count     (w_cnt0),
    .entries   (w_ent0)
  );

  wb_fifo #(.N(N), .M(M), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push1),
    .push_addr (req1.addr),
    .push_data (req1.data),
    .pop       (w_gnt1),
    .head_addr (w_head1_addr),
    .head_data (w_head1_data),
    .count     (w_cnt1),
    .entries   (w_ent1)
  );

  // Grant and pointer next-state. A same-address collision always goes to
  // execute so the later (memory) value is the one that survives.
  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_ptr_nxt = r_ptr;
    if ((w_cnt0 != '0) && (w_cnt1 != '0)) begin
      if (w_head0_addr == w_head1_addr) w_gnt0 = 1'b1;
      else if (r_ptr == REQ_EX)         w_gnt0 = 1'b1;
      else                              w_gnt1 = 1'b1;
    end else if (w_cnt0 != '0) begin
      w_gnt0 = 1'b1;
    end else if (w_cnt1 != '0) begin
      w_gnt1 = 1'b1;
    end
    if (w_gnt0)      w_ptr_nxt = other_req(REQ_EX);
    else if (w_gnt1) w_ptr_nxt = other_req(REQ_MEM);
  end

  assign w_gnt_addr = w_gnt1 ? w_head1_addr : w_head0_addr;
  assign w_gnt_data = w_gnt1 ? w_head1_data : w_head0_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ptr <= REQ_EX;
    else        r_ptr <= w_ptr_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we3         <= 1'b0;
      r_a3          <= '0;
      r_wd3         <= '0;
      r_pc_wr_valid <= 1'b0;
      r_pc_wr_data  <= '0;
    end else begin
      r_we3         <= 1'b0;
      r_pc_wr_valid <= 1'b0;
      if (w_gnt0 || w_gnt1) begin
        if (w_gnt_addr == N'(PC_ADDR)) begin
          r_pc_wr_valid <= 1'b1;
          r_pc_wr_data  <= w_gnt_data;
        end else begin
          r_we3 <= 1'b1;
          r_a3  <= w_gnt_addr;
          r_wd3 <= w_gnt_data;
        end
      end
    end
  end

  // Hazard detect: any live buffered entry, or the write currently on the
  // register-file port. A registered PC write is not a register hazard.
  always_comb begin
    pend1 = r_we3 && (r_a3 == a1);
    pend2 = r_we3 && (r_a3 == a2);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent0[i*(N+1)+N] && (w_ent0[i*(N+1) +: N] == a1)) pend1 = 1'b1;
      if (w_ent1[i*(N+1)+N] && (w_ent1[i*(N+1) +: N] == a1)) pend1 = 1'b1;
      if (w_ent0[i*(N+1)+N] && (w_ent0[i*(N+1) +: N] == a2)) pend2 = 1'b1;
      if (w_ent1[i*(N+1)+N] && (w_ent1[i*(N+1) +: N] == a2)) pend2 = 1'b1;
    end
  end

  assign we3         = r_we3;
  assign a3          = r_a3;
  assign wd3         = r_wd3;
  assign pc_wr_valid = r_pc_wr_valid;
  assign pc_wr_data  = r_pc_wr_data;

endmodule
`default_nettype wire
